switch_egress_port: RTL and testbench



---
 rtl/switch_pkg.sv | 51 +++++
 rtl/egress_fifo.sv | 99 +++++++++
 rtl/switch_egress_port.sv | 126 ++++++++++++
 tb/tb_switch_egress_port.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg
// Shared definitions for the 4-port switch egress path.
//   DEFAULT_DATA_WIDTH / DEFAULT_NUM_PORTS : default payload width and port count
//   port_id_t       : binary-encoded ingress port ID
//   egress_entry_t  : {data, src} record held by an egress FIFO (default widths)
//   occ_state_t     : FIFO occupancy control state
//   onehot_to_id()  : one-hot to binary encoder returning {valid, id}
package switch_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_PORTS  = 4;
  localparam int DEFAULT_PORT_ID_W  = $clog2(DEFAULT_NUM_PORTS);

  // Widest one-hot vector the encoder accepts; narrower vectors are zero-extended.
  localparam int ONEHOT_MAX_W = 32;

  typedef logic [DEFAULT_PORT_ID_W-1:0] port_id_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    port_id_t                      src;
  } egress_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_FULL   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] id;
  } onehot_result_t;

  // valid is set only when exactly one bit is set; id is then its index.
  function automatic onehot_result_t onehot_to_id(input logic [ONEHOT_MAX_W-1:0] onehot);
    onehot_result_t res;
    int unsigned    ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if (onehot[i]) begin
        ones   = ones + 1;
        res.id = 5'(i);
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/egress_fifo.sv
// egress_fifo
// Show-ahead FIFO with an explicit occupancy FSM (EMPTY/ACTIVE/FULL).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wr_data   : write strobe (caller guarantees it is legal) and entry
//   ready_i         : downstream accepts the head entry
//   pop_o           : a pop happens on this edge (valid_o && ready_i)
//   valid_o, full_o : registered occupancy flags
//   count_o         : current occupancy, 0..DEPTH
//   rd_data_o       : head entry, zero whenever the FIFO is empty
module egress_fifo
  import switch_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ready_i,
  output logic             pop_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] rd_data_o
);

  occ_state_t       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop;

  assign pop = valid_q && ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // A simultaneous push and pop leaves occupancy unchanged.
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY:  if (push) state_d = OCC_ACTIVE;
      OCC_ACTIVE: begin
        if (count_d == CNT_W'(DEPTH)) state_d = OCC_FULL;
        else if (count_d == '0)      state_d = OCC_EMPTY;
      end
      OCC_FULL:   if (pop && !push) state_d = OCC_ACTIVE;
      default:    state_d = OCC_EMPTY;
    endcase

    // Flags are registered from the next state so they change on the same
    // edge as the push/pop that causes them.
    valid_d = (state_d != OCC_EMPTY);
    full_d  = (state_d == OCC_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OCC_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the
  // head is masked while empty and the pointers restart together.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign pop_o     = pop;
  assign valid_o   = valid_q;
  assign full_o    = full_q;
  assign count_o   = count_q;
  assign rd_data_o = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/switch_egress_port.sv
// switch_egress_port
// Egress receiver for one switch output port. Captures one-cycle beats from
// the switch, buffers them in a show-ahead FIFO and presents them on a
// valid/ready handshake. Beats that cannot be stored are dropped and flagged.
// Optional feature macro: SWITCH_EGRESS_STATS_EN adds drop_cnt_o and rx_cnt_o.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   valid_in, data_in, source_in: beat from the switch (source is one-hot)
//   valid_o, data_o, src_id_o   : FIFO head, src_id_o binary-encoded
//   ready_i                     : downstream accepts the head
//   count_o, full_o             : occupancy and full flag
//   drop_o                      : one-cycle pulse after a discarded beat
//   err_src_o                   : one-cycle pulse after a non-one-hot source
//   drop_cnt_o, rx_cnt_o        : saturating statistics (macro only)
module switch_egress_port
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter int DEPTH      = 8,
  localparam int ID_W      = $clog2(NUM_PORTS),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]  source_in,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ID_W-1:0]       src_id_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  drop_o,
  output logic                  err_src_o
`ifdef SWITCH_EGRESS_STATS_EN
  ,
  output logic [15:0]                 drop_cnt_o,
  output logic [NUM_PORTS-1:0][15:0]  rx_cnt_o
`endif
);

  localparam int ENTRY_W = DATA_WIDTH + ID_W;

  onehot_result_t     src_chk;
  logic               src_ok;
  logic [ID_W-1:0]    src_id;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               drop_q, drop_d;
  logic               err_q, err_d;

  always_comb begin
    src_chk  = onehot_to_id(ONEHOT_MAX_W'(source_in));
    src_ok   = src_chk.valid;
    src_id   = ID_W'(src_chk.id);
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push     = valid_in && src_ok && (!full_o || pop);
    wr_entry = {data_in, src_id};
    drop_d   = valid_in && !push;
    err_d    = valid_in && !src_ok;
  end

  egress_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_data  (wr_entry),
    .ready_i  (ready_i),
    .pop_o    (pop),
    .valid_o  (valid_o),
    .full_o   (full_o),
    .count_o  (count_o),
    .rd_data_o(rd_entry)
  );

  assign data_o   = rd_entry[ENTRY_W-1:ID_W];
  assign src_id_o = rd_entry[ID_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign drop_o    = drop_q;
  assign err_src_o = err_q;

`ifdef SWITCH_EGRESS_STATS_EN
  logic [15:0]                drop_cnt_q, drop_cnt_d;
  logic [NUM_PORTS-1:0][15:0] rx_cnt_q, rx_cnt_d;

  // Counters advance on the edge that registers drop_o / stores the beat,
  // and hold at all-ones instead of wrapping.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (push && (rx_cnt_q[src_id] != 16'hFFFF)) rx_cnt_d[src_id] = rx_cnt_q[src_id] + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      rx_cnt_q   <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign rx_cnt_o   = rx_cnt_q;
`endif

endmodule

// File: tb/tb_switch_egress_port.sv
// tb_switch_egress_port
// Self-checking bench for switch_egress_port: a table of directed vectors,
// hand-written multi-cycle sequences (overflow, full push/pop, async reset)
// and randomized traffic against a queue-based reference model.
// Define SWITCH_EGRESS_STATS_EN to also cover drop_cnt_o / rx_cnt_o.
module tb_switch_egress_port;

  localparam int DW    = 8;
  localparam int NP    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [NP-1:0] source_in;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [1:0]    src_id_o;
  logic          ready_i;
  logic [3:0]    count_o;
  logic          full_o;
  logic          drop_o;
  logic          err_src_o;
`ifdef SWITCH_EGRESS_STATS_EN
  logic [15:0]         drop_cnt_o;
  logic [NP-1:0][15:0] rx_cnt_o;
`endif

  switch_egress_port #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .source_in(source_in),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .src_id_o (src_id_o),
    .ready_i  (ready_i),
    .count_o  (count_o),
    .full_o   (full_o),
    .drop_o   (drop_o),
    .err_src_o(err_src_o)
`ifdef SWITCH_EGRESS_STATS_EN
    ,
    .drop_cnt_o(drop_cnt_o),
    .rx_cnt_o  (rx_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of stored beats plus last-cycle pulses.
  typedef struct {
    logic [7:0] data;
    logic [1:0] src;
  } entry_t;

  entry_t model_q[$];
  logic   exp_drop;
  logic   exp_err;
  int     model_drops;
  int     model_rx[NP];

  typedef struct {
    string      name;
    logic       v;
    logic [7:0] d;
    logic [3:0] s;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] es;
    logic [3:0] ec;
    logic       ef;
    logic       edrop;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [1:0] srcIndex(logic [3:0] s);
    for (int i = 0; i < NP; i++) if (s[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic void modelClear();
    model_q.delete();
    exp_drop    = 1'b0;
    exp_err     = 1'b0;
    model_drops = 0;
    for (int i = 0; i < NP; i++) model_rx[i] = 0;
  endfunction

  // Advance the model by one clock edge using the inputs that were applied.
  function automatic void modelStep();
    logic   ok, do_pop, do_push;
    entry_t e;
    ok      = ($countones(source_in) == 1);
    do_pop  = (model_q.size() > 0) && ready_i;
    do_push = valid_in && ok && ((model_q.size() < DEPTH) || do_pop);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.data = data_in;
      e.src  = srcIndex(source_in);
      model_q.push_back(e);
      if (model_rx[e.src] < 65535) model_rx[e.src]++;
    end
    exp_drop = valid_in && !do_push;
    exp_err  = valid_in && !ok;
    if (exp_drop && model_drops < 65535) model_drops++;
  endfunction

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] s, input logic r);
    @(negedge clk);
    valid_in  = v;
    data_in   = d;
    source_in = s;
    ready_i   = r;
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic checkOutput(input string tag);
    logic       ev;
    logic [7:0] ed;
    logic [1:0] es;
    ev = (model_q.size() > 0);
    ed = ev ? model_q[0].data : 8'h00;
    es = ev ? model_q[0].src  : 2'd0;
    check({tag, ".valid"}, 32'(valid_o), 32'(ev));
    check({tag, ".data"},  32'(data_o), 32'(ed));
    check({tag, ".src"},   32'(src_id_o), 32'(es));
    check({tag, ".count"}, 32'(count_o), 32'(model_q.size()));
    check({tag, ".full"},  32'(full_o), 32'(model_q.size() == DEPTH));
    check({tag, ".drop"},  32'(drop_o), 32'(exp_drop));
    check({tag, ".err"},   32'(err_src_o), 32'(exp_err));
`ifdef SWITCH_EGRESS_STATS_EN
    check({tag, ".drop_cnt"}, 32'(drop_cnt_o), 32'(model_drops));
    for (int i = 0; i < NP; i++) check({tag, ".rx_cnt"}, 32'(rx_cnt_o[i]), 32'(model_rx[i]));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".valid"}, 32'(valid_o), 32'd0);
    check({tag, ".data"},  32'(data_o), 32'd0);
    check({tag, ".src"},   32'(src_id_o), 32'd0);
    check({tag, ".count"}, 32'(count_o), 32'd0);
    check({tag, ".full"},  32'(full_o), 32'd0);
    check({tag, ".drop"},  32'(drop_o), 32'd0);
    check({tag, ".err"},   32'(err_src_o), 32'd0);
  endtask

  // Asserts reset between clock edges, checks outputs clear immediately,
  // then releases on a falling edge.
  task automatic doReset(input string tag);
    valid_in  = 1'b0;
    data_in   = '0;
    source_in = '0;
    ready_i   = 1'b0;
    rst       = 1'b1;
    #1;
    modelClear();
    checkAllZero(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rprob;
    logic [3:0] s;

    valid_in  = 1'b0;
    data_in   = '0;
    source_in = '0;
    ready_i   = 1'b0;
    rst       = 1'b1;
    modelClear();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // name, v, d, s, r -> valid, data, src, count, full, drop, err
    vecs.push_back('{"single_push",   1'b1, 8'hA5, 4'b0100, 1'b0, 1'b1, 8'hA5, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"single_pop",    1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"bad_zero",      1'b1, 8'h11, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"bad_multi",     1'b1, 8'h22, 4'b0011, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"idle",          1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"push_src3",     1'b1, 8'h77, 4'b1000, 1'b0, 1'b1, 8'h77, 2'd3, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"bad_held",      1'b1, 8'h55, 4'b1001, 1'b0, 1'b1, 8'h77, 2'd3, 4'd1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"pop_src3",      1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"push_src0",     1'b1, 8'h99, 4'b0001, 1'b0, 1'b1, 8'h99, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"push_pop_one",  1'b1, 8'h44, 4'b0010, 1'b1, 1'b1, 8'h44, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"final_pop",     1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].r);
      check({vecs[i].name, ".valid"}, 32'(valid_o), 32'(vecs[i].ev));
      check({vecs[i].name, ".data"},  32'(data_o), 32'(vecs[i].ed));
      check({vecs[i].name, ".src"},   32'(src_id_o), 32'(vecs[i].es));
      check({vecs[i].name, ".count"}, 32'(count_o), 32'(vecs[i].ec));
      check({vecs[i].name, ".full"},  32'(full_o), 32'(vecs[i].ef));
      check({vecs[i].name, ".drop"},  32'(drop_o), 32'(vecs[i].edrop));
      check({vecs[i].name, ".err"},   32'(err_src_o), 32'(vecs[i].eerr));
    end

    // Fill and overflow: nine beats with no reader.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(i), 4'b0001, 1'b0);
      checkOutput("fill");
      if (i == 7) check("fill.full_at_8", 32'(full_o), 32'd1);
      if (i == 8) begin
        check("overflow.drop", 32'(drop_o), 32'd1);
        check("overflow.count", 32'(count_o), 32'd8);
      end
    end
    for (int k = 0; k < 8; k++) begin
      check("drain.order", 32'(data_o), 32'(k));
      applyStimulus(1'b0, 8'h00, 4'b0000, 1'b1);
      checkOutput("drain");
    end

    // Sustained push and pop while full, walking the pointers round.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 4'b0100, 1'b0);
      checkOutput("prefill");
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 4'b0100, 1'b1);
      checkOutput("fullpp");
      check("fullpp.count", 32'(count_o), 32'd8);
      check("fullpp.nodrop", 32'(drop_o), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 4'b0000, 1'b1);
      checkOutput("fullpp_drain");
    end

    // Reset in the middle of a cycle with five entries stored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 4'b0010, 1'b0);
      checkOutput("prereset");
    end
    check("prereset.count", 32'(count_o), 32'd5);
    #3;
    doReset("midreset");
    applyStimulus(1'b1, 8'h3C, 4'b1000, 1'b0);
    check("postreset.data", 32'(data_o), 32'h3C);
    check("postreset.count", 32'(count_o), 32'd1);
    checkOutput("postreset");
    applyStimulus(1'b0, 8'h00, 4'b0000, 1'b1);
    checkOutput("postreset_pop");

`ifdef SWITCH_EGRESS_STATS_EN
    // Three beats from source 1, fill the rest, then two overflow drops.
    doReset("stats_reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(i), 4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i), 4'b0001, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'hEE, 4'b0100, 1'b0);
    check("stats.rx1", 32'(rx_cnt_o[1]), 32'd3);
    check("stats.drop_cnt", 32'(drop_cnt_o), 32'd2);
    checkOutput("stats");
    doReset("stats_clear");
`endif

    // Randomized traffic with changing reader pressure.
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0: rprob = 15;
        1: rprob = 50;
        2: rprob = 95;
        default: rprob = 35;
      endcase
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 9) < 8) s = 4'(1 << $urandom_range(0, 3));
        else s = 4'($urandom);
        applyStimulus(($urandom_range(0, 99) < 75), 8'($urandom), s,
                      ($urandom_range(0, 99) < rprob));
        checkOutput("random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
